// File: rtl/twiddle_pkg.sv
// twiddle_pkg: shared index widths, quadrant encoding and saturating negate for the twiddle path
package twiddle_pkg;
  localparam int TW_IDX_W = 6;
  localparam int TW_ROM_AW = 4;
  typedef enum logic [1:0] {TW_Q0, TW_Q1, TW_Q2, TW_Q3} tw_quad_e;
  // Operates on a w-bit value held in the low bits; the most negative code clamps to max positive.
  function automatic logic [31:0] sat_neg(logic [31:0] x, int w);
    return (x == (32'd1 << (w - 1))) ? (32'd1 << (w - 1)) - 32'd1 : -x;
  endfunction
endpackage

// File: rtl/twiddle_rotate.sv
// twiddle_rotate: registered quadrant fold of a first-quadrant ROM value
// Optional TWIDDLE_ARB_CONJ_EN adds the conj input (imaginary part negated after rotation).
module twiddle_rotate import twiddle_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  tw_quad_e         quad,
`ifdef TWIDDLE_ARB_CONJ_EN
  input  logic             conj,
`endif
  output logic [WIDTH-1:0] re,
  output logic [WIDTH-1:0] im
);
  logic [WIDTH-1:0] na, nb, re_n, im_n, im_r;
  assign na = WIDTH'(sat_neg(32'(a), WIDTH));
  assign nb = WIDTH'(sat_neg(32'(b), WIDTH));
  always_comb begin
    re_n = quad == TW_Q0 ? a : quad == TW_Q1 ? b : quad == TW_Q2 ? na : nb;
    im_n = quad == TW_Q0 ? b : quad == TW_Q1 ? na : quad == TW_Q2 ? nb : a;
`ifdef TWIDDLE_ARB_CONJ_EN
    im_r = conj ? WIDTH'(sat_neg(32'(im_n), WIDTH)) : im_n;
`else
    im_r = im_n;
`endif
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      re <= '0;
      im <= '0;
    end else if (load) begin
      re <= re_n;
      im <= im_r;
    end
endmodule

// File: rtl/twiddle_arbiter.sv
// twiddle_arbiter: round-robin sharing of the 16-entry twiddle ROM with quadrant folding
// Optional TWIDDLE_ARB_CONJ_EN adds req_conj for inverse-FFT conjugation.
module twiddle_arbiter import twiddle_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [TW_IDX_W*NREQ-1:0] req_index,
`ifdef TWIDDLE_ARB_CONJ_EN
  input  logic [NREQ-1:0]          req_conj,
`endif
  output logic [NREQ-1:0]          req_ready,
  output logic [TW_ROM_AW-1:0]     rom_addr,
  input  logic [WIDTH-1:0]         rom_re,
  input  logic [WIDTH-1:0]         rom_im,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [WIDTH-1:0]         rsp_re,
  output logic [WIDTH-1:0]         rsp_im
);
  logic [1:0] rr, gid, idx, s1_id;
  logic hit, s1_valid, s1_conj;
  tw_quad_e s1_quad;
  logic [TW_IDX_W-1:0] gk;
  always_comb begin
    hit = 1'b0;
    gid = '0;
    idx = '0;
    for (int o = 0; o < NREQ; o++) begin
      idx = 2'((int'(rr) + o) % NREQ);
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        gid = idx;
      end
    end
  end
  assign gk        = req_index[TW_IDX_W*gid +: TW_IDX_W];
  assign req_ready = hit ? NREQ'(1) << gid : '0;
  assign rom_addr  = hit ? gk[TW_ROM_AW-1:0] : '0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rr        <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_quad   <= TW_Q0;
      s1_conj   <= 1'b0;
      rsp_valid <= '0;
    end else begin
      s1_valid  <= hit;
      rsp_valid <= s1_valid ? NREQ'(1) << s1_id : '0;
      if (hit) begin
        rr      <= 2'((int'(gid) + 1) % NREQ);
        s1_id   <= gid;
        s1_quad <= tw_quad_e'(gk[TW_IDX_W-1 -: 2]);
`ifdef TWIDDLE_ARB_CONJ_EN
        s1_conj <= req_conj[gid];
`else
        s1_conj <= 1'b0;
`endif
      end
    end
  twiddle_rotate #(.WIDTH(WIDTH)) u_rot (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (s1_valid),
    .a       (rom_re),
    .b       (rom_im),
    .quad    (s1_quad),
`ifdef TWIDDLE_ARB_CONJ_EN
    .conj    (s1_conj),
`endif
    .re      (rsp_re),
    .im      (rsp_im)
  );
endmodule

// File: tb/tb_twiddle_arbiter.sv
// tb_twiddle_arbiter: directed and randomized checks of twiddle_arbiter against a complex-arithmetic model
module tb_twiddle_arbiter;
  localparam int NREQ = 3;
  typedef struct packed {
    logic        v;
    logic [1:0]  id;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [6*NREQ-1:0] req_index = '0;
`ifdef TWIDDLE_ARB_CONJ_EN
  logic [NREQ-1:0] req_conj = '0;
`endif
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [3:0] rom_addr;
  logic [15:0] rom_re = '0, rom_im = '0, rsp_re, rsp_im;
  logic [15:0] tab_re[16], tab_im[16];
  int n_cmp = 0, n_bad = 0;
  int m_rr = 0;
  exp_t q1 = '0, q2 = '0;
  logic [15:0] last_re = '0, last_im = '0;

  twiddle_arbiter #(.WIDTH(16), .NREQ(NREQ)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_index (req_index),
`ifdef TWIDDLE_ARB_CONJ_EN
    .req_conj  (req_conj),
`endif
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_re    (rom_re),
    .rom_im    (rom_im),
    .rsp_valid (rsp_valid),
    .rsp_re    (rsp_re),
    .rsp_im    (rsp_im)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rom_re <= tab_re[rom_addr];
    rom_im <= tab_im[rom_addr];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] clamp(int v);
    return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : 16'(v);
  endfunction

  // Multiply a+jb by (-j)^q in plain integers, then clamp to Q1.15.
  task automatic rot(input logic [15:0] a, input logic [15:0] b, input int q, input bit cj,
                     output logic [15:0] re, output logic [15:0] im);
    int ai, bi, cr, ci, t;
    ai = $signed(a);
    bi = $signed(b);
    cr = q == 0 ? 1 : q == 2 ? -1 : 0;
    ci = q == 1 ? -1 : q == 3 ? 1 : 0;
    re = clamp(cr * ai - ci * bi);
    im = clamp(cr * bi + ci * ai);
    if (cj) begin
      t = $signed(im);
      im = clamp(-t);
    end
  endtask

  always @(negedge clock) begin
    int g, k;
    bit cj;
    logic [15:0] r, i;
    if (!reset_n) begin
      m_rr = 0;
      q1 = '0;
      q2 = '0;
      last_re = '0;
      last_im = '0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_re", rsp_re, 0);
      chk("rst_rsp_im", rsp_im, 0);
      if (req_valid == '0) begin
        chk("rst_ready", req_ready, 0);
        chk("rst_addr", rom_addr, 0);
      end
    end else begin
      chk("rsp_valid", rsp_valid, q2.v ? 32'(1) << q2.id : 0);
      if (q2.v) begin
        last_re = q2.re;
        last_im = q2.im;
      end
      chk("rsp_re", rsp_re, last_re);
      chk("rsp_im", rsp_im, last_im);
      g = -1;
      for (int o = 0; o < NREQ; o++)
        if (g < 0 && req_valid[(m_rr + o) % NREQ]) g = (m_rr + o) % NREQ;
      k = g < 0 ? 0 : int'(req_index[6*g +: 6]);
      chk("req_ready", req_ready, g < 0 ? 0 : 32'(1) << g);
      chk("rom_addr", rom_addr, k % 16);
      q2 = q1;
      q1 = '0;
      if (g >= 0) begin
        m_rr = (g + 1) % NREQ;
        cj = 1'b0;
`ifdef TWIDDLE_ARB_CONJ_EN
        cj = req_conj[g];
`endif
        rot(tab_re[k % 16], tab_im[k % 16], k / 16, cj, r, i);
        q1 = {1'b1, 2'(g), r, i};
      end
    end
  end

  task automatic single(int id, int k, bit cj, logic [3:0] eaddr, logic [15:0] ere, logic [15:0] eim);
    @(posedge clock);
    #1;
    req_valid = NREQ'(1) << id;
    req_index[6*id +: 6] = 6'(k);
`ifdef TWIDDLE_ARB_CONJ_EN
    req_conj = NREQ'(cj) << id;
`endif
    @(negedge clock);
    chk("dir_ready", req_ready, 32'(1) << id);
    chk("dir_addr", rom_addr, eaddr);
    @(posedge clock);
    #1;
    req_valid = '0;
    @(posedge clock);
    @(negedge clock);
    chk("dir_rsp_valid", rsp_valid, 32'(1) << id);
    chk("dir_rsp_re", rsp_re, ere);
    chk("dir_rsp_im", rsp_im, eim);
  endtask

  initial begin
    int c0, c1;
    for (int i = 0; i < 16; i++) begin
      tab_re[i] = 16'($urandom);
      tab_im[i] = 16'($urandom);
    end
    tab_re[0] = 16'h7fff; tab_im[0] = 16'h0000;
    tab_re[1] = 16'h7f62; tab_im[1] = 16'hef89;
    tab_re[5] = 16'h8000; tab_im[5] = 16'h1234;
    tab_re[9] = 16'h8000; tab_im[9] = 16'h8000;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    single(0, 0, 1'b0, 4'd0, 16'h7fff, 16'h0000);
    single(0, 17, 1'b0, 4'd1, 16'hef89, 16'h809e);
    single(1, 33, 1'b0, 4'd1, 16'h809e, 16'h1077);
    single(2, 49, 1'b0, 4'd1, 16'h1077, 16'h7f62);
    single(1, 37, 1'b0, 4'd5, 16'h7fff, 16'hedcc);
`ifdef TWIDDLE_ARB_CONJ_EN
    single(0, 1, 1'b1, 4'd1, 16'h7f62, 16'h1077);
`endif
    // alternation from a fresh pointer with two requesters held
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    req_index = 18'($urandom);
    req_valid = 3'b011;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i < 6) chk("alt_ready", req_ready, i % 2 ? 2 : 1);
      if (i >= 2) chk("b2b_rsp", 32'(rsp_valid != '0), 1);
      c0 += int'(rsp_valid[0]);
      c1 += int'(rsp_valid[1]);
      @(posedge clock);
      if (i == 5) #1 req_valid = '0;
    end
    chk("alt_cnt0", c0, 3);
    chk("alt_cnt1", c1, 3);
    // reset one cycle after acceptance discards the request
    @(posedge clock);
    #1 req_valid = 3'b001;
    @(posedge clock);
    #1 reset_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("flush_rsp_valid", rsp_valid, 0);
    end
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock);
      #1;
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      req_valid = reset_n ? NREQ'($urandom) : '0;
      req_index = 18'($urandom);
`ifdef TWIDDLE_ARB_CONJ_EN
      req_conj = NREQ'($urandom);
`endif
    end
    @(posedge clock);
    #1 req_valid = '0;
    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/twiddle_arbiter.md
# twiddle_arbiter

Shares the single 16-entry registered Twiddle ROM between `NREQ` butterfly-stage requesters of the 64-point FFT. Each requester asks for a full W64^k factor (k = 0..63). The block arbitrates round-robin and drives the ROM address with k[3:0]. It then folds the returned first-quadrant value into the correct quadrant using k[5:4], and returns a tagged response two cycles after acceptance. It sits between the per-stage address counters and the Twiddle ROM instance.

## Interface
Parameters:
- `WIDTH`, 16: twiddle component width, two's complement Q1.15.
- `NREQ`, 2: number of requesters (2..4).

Ports:
- `clock`  in  1  the only clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request strobe per requester.
- `req_index`  in  6*NREQ  twiddle index k, requester i at bits [6i+5:6i].
- `req_ready`  out  NREQ  grant; a request is accepted on an edge where valid and ready are both high.
- `rom_addr`  out  4  address to the Twiddle ROM (ROM registers its output on the same edge).
- `rom_re`, `rom_im`  in  WIDTH each  ROM outputs, valid the cycle after the address is sampled.
- `rsp_valid`  out  NREQ  one-cycle response pulse, one-hot.
- `rsp_re`, `rsp_im`  out  WIDTH each  rotated twiddle, shared by all requesters, qualified by `rsp_valid`.

## Operation
- Arbitration is combinational round-robin over `req_valid`, starting at pointer `rr`.
  - At most one `req_ready` is high. It is zero when no request is valid.
  - `req_ready` does not depend on downstream state. Responses cannot be back-pressured.
- `rom_addr` equals the granted k[3:0], or 0 when there is no grant.
- On acceptance, `rr` moves to (granted id + 1) mod NREQ. With no acceptance, `rr` holds.
- Stage 1, the edge of acceptance: register `s1_valid`, `s1_id`, `s1_quad` = k[5:4] (and `s1_conj` if configured). The ROM captures the address on the same edge.
- Stage 2, the next edge: rotate (`rom_re` = a, `rom_im` = b), register the result, and pulse `rsp_valid[s1_id]`.
  - quad 0: re = a, im = b.
  - quad 1 (×−j): re = b, im = −a.
  - quad 2 (×−1): re = −a, im = −b.
  - quad 3 (×+j): re = −b, im = a.
- Negation is saturating. The input 16'h8000 negates to 16'h7fff. All other values use the ordinary two's complement negate.
- `rsp_re` and `rsp_im` hold their last value when `rsp_valid` is zero.

## Timing
- Latency: exactly 2 edges from the acceptance edge to `rsp_valid` high.
- Throughput: one accepted request per cycle, sustained.
- Simultaneous requests: served in round-robin order. A requester whose valid is held waits at most NREQ−1 cycles.
- A requester may change `req_index` or drop `req_valid` freely while it is not granted.
- Reset asserted at any time:
  - `s1_valid` = 0, `rsp_valid` = 0, `rsp_re` = `rsp_im` = 0, `rr` = 0.
  - In-flight requests are discarded and no response is produced for them.
- After reset release: `req_ready` follows `req_valid` from the first cycle, and `rom_addr` = 0 when idle.

## Configuration
- `TWIDDLE_ARB_CONJ_EN` defined:
  - Adds input `req_conj` (NREQ bits), sampled with the request.
  - When set, the output is conjugated (im negated, saturating) after the quadrant rotation, for inverse-FFT stages.
- Undefined: no `req_conj` port, and no conjugation logic is built.

## Structure
- Shared package `twiddle_pkg`:
  - `TW_IDX_W` = 6 and `TW_ROM_AW` = 4.
  - Quadrant enum `TW_Q0`..`TW_Q3`.
  - Saturating-negate function.
- Sub-module `twiddle_rotate`: registered stage-2 datapath with inputs a, b, quad and optional conj, and outputs re and im. The arbiter top holds `rr`, the grant logic and stage 1.

## Test plan
- Requester 0 with k = 0, idle otherwise -> `rom_addr` = 0. Two cycles later `rsp_valid` = 01 with re = 7fff, im = 0000.
- k = 17 -> `rom_addr` = 1, response re = ef89, im = 809e.
- k = 33 -> re = 809e, im = 1077.
- k = 49 -> re = 1077, im = 7f62.
- Both requesters held valid for 6 cycles (NREQ = 2) -> grants alternate 0,1,0,1,0,1.
  - Each gets 3 responses, each 2 cycles after its grant.
  - Back-to-back `rsp_valid` pulses, with no gaps.
- Reset asserted one cycle after acceptance -> no `rsp_valid` ever appears for that request. All outputs are 0 during reset.
- With `TWIDDLE_ARB_CONJ_EN`: k = 1 with conj = 1 -> re = 7f62, im = 1077.
- Stage-2 input with a = 8000 forced (bench-driven ROM model), quad 2 -> re = 7fff.
